// File: rtl/sms_pkg.sv
// Shared definitions for the Simon memory-mapped peripherals: colour codes,
// bus addresses, status-word layout and the sequence-player state type.
package sms_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] BLUE   = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
  localparam logic [1:0] YELLOW = 2'b11;

  // Addresses 5..9 belong to the button, LED, audio and servo peripherals.
  localparam logic [11:0] ADDR_PERIPH_FIRST = 12'd5;
  localparam logic [11:0] ADDR_PERIPH_LAST  = 12'd9;
  localparam logic [11:0] ADDR_DATA         = 12'd10;
  localparam logic [11:0] ADDR_CTRL         = 12'd11;
  localparam logic [11:0] ADDR_STAT         = 12'd12;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  localparam int STAT_COUNT_W  = 6;
  localparam int STAT_BUSY_BIT = 8;
  localparam int STAT_FULL_BIT = 9;
  localparam int STAT_ERR_BIT  = 10;
  localparam int STAT_DONE_BIT = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } play_state_e;

  // clog2 that never yields a zero-width vector
  function automatic int safe_clog2(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter: load wins, otherwise counts down and parks at zero.
module cycle_timer #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (value_q != '0) begin
      value_d = value_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/sequence_player.sv
// Stores a Simon colour sequence written over the data bus and replays it
// on the LED/audio enables with fixed on/gap timing after a start command.
module sequence_player
  import sms_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  output logic        stat_hit,
  output logic [31:0] stat_data,
  output logic [1:0]  color,
  output logic        active,
  output logic        done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = safe_clog2(DEPTH);
  localparam int TW = safe_clog2((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

  play_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic          done_flag_q, done_flag_d;
  logic          done_q, done_d;
  logic [1:0]    color_q, color_d;

  logic [1:0]    buf_q [DEPTH];
  logic          buf_we;

  logic          timer_load;
  logic [TW-1:0] timer_load_value;
  logic [TW-1:0] timer_value;
  logic          timer_zero;

  logic data_wr, ctrl_wr, busy, full, last_entry;

  cycle_timer #(.W(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .value      (timer_value),
    .zero       (timer_zero)
  );

  assign data_wr    = wren && (address_dmem == ADDR_DATA);
  assign ctrl_wr    = wren && (address_dmem == ADDR_CTRL);
  assign busy       = (state_q != ST_IDLE);
  assign full       = (count_q == CW'(DEPTH));
  assign last_entry = (CW'(idx_q) == count_q - CW'(1));

  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    idx_d            = idx_q;
    err_d            = err_q;
    done_flag_d      = done_flag_q;
    done_d           = 1'b0;
    color_d          = color_q;
    buf_we           = 1'b0;
    timer_load       = 1'b0;
    timer_load_value = ON_LOAD;

    case (state_q)
      ST_ON: begin
        if (timer_zero) begin
          state_d          = ST_GAP;
          timer_load       = 1'b1;
          timer_load_value = OFF_LOAD;
        end
      end
      ST_GAP: begin
        if (timer_zero) begin
          if (last_entry) begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            done_flag_d = 1'b1;
          end else begin
            idx_d      = idx_q + IW'(1);
            state_d    = ST_ON;
            timer_load = 1'b1;
            color_d    = buf_q[idx_d];
          end
        end
      end
      default: ;
    endcase

    // Bus commands override the playback step; clear beats everything.
    if (ctrl_wr && data[CTRL_CLEAR_BIT]) begin
      count_d     = '0;
      err_d       = 1'b0;
      done_flag_d = 1'b0;
      done_d      = 1'b0;
      state_d     = ST_IDLE;
    end else if (ctrl_wr && data[CTRL_START_BIT]) begin
      if (!busy && (count_q != '0)) begin
        idx_d       = '0;
        done_flag_d = 1'b0;
        state_d     = ST_ON;
        timer_load  = 1'b1;
        color_d     = buf_q[idx_d];
      end else begin
        err_d = 1'b1;
      end
    end else if (data_wr) begin
      if (busy || full) begin
        err_d = 1'b1;
      end else begin
        buf_we  = 1'b1;
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      done_flag_q <= 1'b0;
      done_q      <= 1'b0;
      color_q     <= RED;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      done_flag_q <= done_flag_d;
      done_q      <= done_d;
      color_q     <= color_d;
    end
  end

  // Sequence storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clock) begin
    if (buf_we) begin
      buf_q[count_q[IW-1:0]] <= data[1:0];
    end
  end

  always_comb begin
    stat_data                       = '0;
    stat_data[STAT_COUNT_W-1:0]     = STAT_COUNT_W'(count_q);
    stat_data[STAT_BUSY_BIT]        = busy;
    stat_data[STAT_FULL_BIT]        = full;
    stat_data[STAT_ERR_BIT]         = err_q;
    stat_data[STAT_DONE_BIT]        = done_flag_q;
  end

  assign stat_hit = (address_dmem == ADDR_STAT);
  assign active   = (state_q == ST_ON);
  assign color    = color_q;
  assign done     = done_q;

  logic unused_bits;
  assign unused_bits = ^{data[31:2], timer_value};

endmodule

// File: tb/tb_sequence_player.sv
// Randomised self-checking bench for sequence_player against a queue-based
// model of the stored sequence and its on/gap playback schedule.
module tb_sequence_player;
  import sms_pkg::*;

  localparam int DEPTH = 32;
  localparam int ON    = 4;
  localparam int OFF   = 2;
  localparam int PER   = ON + OFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wren = 1'b0;
  logic [11:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        stat_hit;
  logic [31:0] stat_data;
  logic [1:0]  color;
  logic        active;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [1:0] m_seq[$];
  bit         m_err;
  bit         m_done_flag;
  bit         m_busy;

  sequence_player #(.DEPTH(DEPTH), .ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clock        (clock),
    .reset        (reset),
    .wren         (wren),
    .address_dmem (address_dmem),
    .data         (data),
    .stat_hit     (stat_hit),
    .stat_data    (stat_data),
    .color        (color),
    .active       (active),
    .done         (done)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] v;
    v        = '0;
    v[5:0]   = 6'(m_seq.size());
    v[8]     = m_busy;
    v[9]     = (m_seq.size() == DEPTH);
    v[10]    = m_err;
    v[11]    = m_done_flag;
    return v;
  endfunction

  function automatic void model_bus(input logic [11:0] a, input logic [31:0] d);
    if (a == ADDR_CTRL) begin
      if (d[1]) begin
        m_seq.delete();
        m_err       = 1'b0;
        m_done_flag = 1'b0;
        m_busy      = 1'b0;
      end else if (d[0]) begin
        if (!m_busy && m_seq.size() > 0) m_done_flag = 1'b0;
        else m_err = 1'b1;
      end
    end else if (a == ADDR_DATA) begin
      if (m_busy || m_seq.size() == DEPTH) m_err = 1'b1;
      else m_seq.push_back(d[1:0]);
    end
  endfunction

  // Called at a falling edge; the store is sampled at the next rising edge.
  task automatic store(input logic [11:0] a, input logic [31:0] d);
    wren = 1'b1; address_dmem = a; data = d;
    model_bus(a, d);
    @(negedge clock);
    wren = 1'b0; address_dmem = '0; data = '0;
  endtask

  task automatic read_stat(output logic [31:0] v, output logic hit);
    address_dmem = ADDR_STAT;
    #1;
    v   = stat_data;
    hit = stat_hit;
    address_dmem = '0;
  endtask

  // Start playback and compare every cycle against the ideal schedule;
  // optionally inject a data store / start at given cycle offsets.
  task automatic play(input string tag, input int inj_data_k, input int inj_start_k);
    logic [1:0] snap[$];
    int n;
    logic exp_active;
    logic [1:0] inj_col;
    snap = m_seq;
    n = snap.size();
    store(ADDR_CTRL, 32'h1);
    m_busy = 1'b1;
    for (int k = 0; k <= n * PER; k++) begin
      exp_active = (k < n * PER) && ((k % PER) < ON);
      checks++;
      if (active !== exp_active) begin
        failures++;
        $display("FAIL %s active k=%0d got=%b exp=%b", tag, k, active, exp_active);
      end
      if (k < n * PER) begin
        checks++;
        if (color !== snap[k / PER]) begin
          failures++;
          $display("FAIL %s color k=%0d got=%0d exp=%0d", tag, k, color, snap[k / PER]);
        end
      end
      checks++;
      if (done !== (k == n * PER)) begin
        failures++;
        $display("FAIL %s done k=%0d got=%b exp=%b", tag, k, done, (k == n * PER));
      end
      if (k == n * PER) begin
        m_busy      = 1'b0;
        m_done_flag = 1'b1;
      end else if (k == inj_data_k) begin
        inj_col = 2'($urandom_range(0, 3));
        store(ADDR_DATA, {30'd0, inj_col});
      end else if (k == inj_start_k) begin
        store(ADDR_CTRL, 32'h1);
      end else begin
        @(negedge clock);
      end
    end
    $display("play %s: %0d entries checked", tag, n);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic hit;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({active, color, done} !== 4'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000", {active, color, done});
    end
    #2 reset = 1'b1;
    @(negedge clock);
    m_seq.delete(); m_err = 0; m_done_flag = 0; m_busy = 0;
    read_stat(v, hit);
    checks++;
    if (v !== exp_status() || hit !== 1'b1) begin
      failures++;
      $display("FAIL reset_status got=%h hit=%b exp=%h hit=1", v, hit, exp_status());
    end
    address_dmem = ADDR_DATA;
    #1;
    checks++;
    if (stat_hit !== 1'b0) begin
      failures++;
      $display("FAIL stat_hit_other_addr got=%b exp=0", stat_hit);
    end
    address_dmem = '0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [31:0] v;
    logic hit;
    store(ADDR_DATA, 32'd2);
    store(ADDR_DATA, 32'd0);
    store(ADDR_DATA, 32'd3);
    read_stat(v, hit);
    checks++;
    if (v !== 32'h003 || v !== exp_status()) begin
      failures++;
      $display("FAIL basic_load_status got=%h exp=%h", v, 32'h003);
    end
    play("basic", -1, -1);
    read_stat(v, hit);
    checks++;
    if (v !== 32'h803 || v !== exp_status()) begin
      failures++;
      $display("FAIL basic_done_status got=%h exp=%h", v, 32'h803);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_width got=%b exp=0", done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic hit;
    store(ADDR_CTRL, 32'h2);
    for (int r = 1; r <= 4; r++) begin
      store(ADDR_DATA, 32'($urandom_range(0, 3)));
      play($sformatf("round%0d", r), -1, -1);
      read_stat(v, hit);
      checks++;
      if (v !== exp_status()) begin
        failures++;
        $display("FAIL round%0d_status got=%h exp=%h", r, v, exp_status());
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic hit;
    store(ADDR_CTRL, 32'h2);
    for (int i = 0; i <= DEPTH; i++) store(ADDR_DATA, 32'($urandom));
    read_stat(v, hit);
    checks++;
    if (v !== exp_status() || v !== 32'h620) begin
      failures++;
      $display("FAIL overflow_status got=%h exp=%h", v, 32'h620);
    end
    store(ADDR_CTRL, 32'h3);
    read_stat(v, hit);
    checks++;
    if (v !== 32'h000) begin
      failures++;
      $display("FAIL clear_status got=%h exp=%h", v, 32'h000);
    end
    store(ADDR_CTRL, 32'h1);
    read_stat(v, hit);
    checks++;
    if (v !== exp_status() || v !== 32'h400 || active !== 1'b0) begin
      failures++;
      $display("FAIL empty_start got=%h active=%b exp=%h active=0", v, active, 32'h400);
    end
  endtask

  task automatic test_busy_ignored();
    logic [31:0] v;
    logic hit;
    int dk, sk, span;
    store(ADDR_CTRL, 32'h2);
    for (int i = 0; i < 3; i++) store(ADDR_DATA, 32'($urandom_range(0, 3)));
    span = 3 * PER - 1;
    dk = $urandom_range(0, span - 1);
    sk = (dk + 1 + $urandom_range(0, 5)) % span;
    play("busy", dk, sk);
    read_stat(v, hit);
    checks++;
    if (v !== exp_status() || v !== 32'hC03) begin
      failures++;
      $display("FAIL busy_status got=%h exp=%h", v, 32'hC03);
    end
  endtask

  task automatic test_clear_mid_on();
    logic [31:0] v;
    logic hit;
    int ck;
    store(ADDR_CTRL, 32'h2);
    store(ADDR_DATA, 32'($urandom_range(0, 3)));
    store(ADDR_DATA, 32'($urandom_range(0, 3)));
    store(ADDR_CTRL, 32'h1);
    m_busy = 1'b1;
    ck = PER + $urandom_range(0, ON - 1);
    for (int k = 0; k < ck; k++) @(negedge clock);
    checks++;
    if (active !== 1'b1) begin
      failures++;
      $display("FAIL clear_pre_active got=%b exp=1", active);
    end
    store(ADDR_CTRL, 32'h2);
    read_stat(v, hit);
    checks++;
    if (v !== 32'h000 || active !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL clear_mid_on stat=%h active=%b done=%b exp stat=000 active=0 done=0",
               v, active, done);
    end
    for (int k = 0; k < 3 * PER; k++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || active !== 1'b0) begin
        failures++;
        $display("FAIL clear_quiet k=%0d done=%b active=%b exp 0 0", k, done, active);
      end
    end
    $display("test_clear_mid_on cleared at k=%0d", ck);
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    logic hit;
    store(ADDR_CTRL, 32'h2);
    store(ADDR_DATA, {30'd0, GREEN});
    store(ADDR_DATA, {30'd0, YELLOW});
    store(ADDR_DATA, {30'd0, BLUE});
    store(ADDR_CTRL, 32'h1);
    m_busy = 1'b1;
    repeat (PER + ON) @(negedge clock);
    checks++;
    if (active !== 1'b0 || color !== YELLOW) begin
      failures++;
      $display("FAIL pre_reset_gap active=%b color=%0d exp active=0 color=3", active, color);
    end
    address_dmem = ADDR_STAT;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({active, color, done} !== 4'b0 || stat_data !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_gap out=%b stat=%h exp out=0000 stat=0",
               {active, color, done}, stat_data);
    end
    @(negedge clock);
    #2 reset = 1'b1;
    address_dmem = '0;
    m_seq.delete(); m_err = 0; m_done_flag = 0; m_busy = 0;
    @(negedge clock);
    read_stat(v, hit);
    checks++;
    if (v !== exp_status() || v !== 32'h000) begin
      failures++;
      $display("FAIL post_reset_status got=%h exp=%h", v, 32'h000);
    end
    // Reset landing inside an ON phase must drop the enable at once.
    store(ADDR_DATA, {30'd0, BLUE});
    store(ADDR_CTRL, 32'h1);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (active !== 1'b0 || color !== RED) begin
      failures++;
      $display("FAIL async_reset_on active=%b color=%0d exp active=0 color=0", active, color);
    end
    @(negedge clock);
    #2 reset = 1'b1;
    m_seq.delete(); m_err = 0; m_done_flag = 0; m_busy = 0;
    @(negedge clock);
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_busy_ignored();
    test_clear_mid_on();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
